// File: rtl/bmult_prod_accum_if.sv
// Product-in / result-out bus for the bit-heap multiplier product accumulator.
// master = product producer + result consumer, slave = accumulator.
interface bmult_prod_accum_if #(
   parameter int P_W   = 16,
   parameter int ACC_W = 24,
   parameter int CNT_W = 5
);
   // Both channels use strict valid/ready: a transfer happens on a rising edge
   // where valid && ready; valid and its payload hold until that edge, and a
   // valid never waits on ready combinationally.
   logic             p_valid;
   logic             p_ready;
   logic [P_W-1:0]   p_data;
   logic             p_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;
   logic [CNT_W-1:0] out_cnt;
   logic             out_ovf;

   modport master (
      output p_valid, p_data, p_last, out_ready,
      input  p_ready, out_valid, out_data, out_cnt, out_ovf
   );

   modport slave (
      input  p_valid, p_data, p_last, out_ready,
      output p_ready, out_valid, out_data, out_cnt, out_ovf
   );
endinterface

// File: rtl/bmult_prod_accum.sv
// Accumulates multiplier products into a dot-product sum, closed by p_last or MAX_TERMS.
// Define BMULT_ACC_SAT_EN to saturate the sum at all-ones instead of wrapping.
module bmult_prod_accum #(
   parameter int P_W       = 16,
   parameter int ACC_W     = 24,
   parameter int MAX_TERMS = 16,
   parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   bmult_prod_accum_if.slave       bus,
   output logic [1:0]              o_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

   state_t             r_state;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ovf;
   logic               r_out_valid;
   logic [ACC_W-1:0]   r_out_data;
   logic [CNT_W-1:0]   r_out_cnt;
   logic               r_out_ovf;

   logic               w_p_ready;
   logic               w_accept;
   logic               w_first;
   logic [ACC_W-1:0]   w_base_acc;
   logic [CNT_W-1:0]   w_base_cnt;
   logic               w_base_ovf;
   logic [ACC_W:0]     w_sum_full;
   logic               w_carry;
   logic [ACC_W-1:0]   w_sum_next;
   logic [CNT_W-1:0]   w_cnt_next;
   logic               w_ovf_next;
   logic               w_term;

   assign w_p_ready  = (r_state != S_HOLD);
   assign w_accept   = bus.p_valid && w_p_ready;

   // A term accepted from IDLE starts a fresh sum regardless of stale registers.
   assign w_first    = (r_state == S_IDLE);
   assign w_base_acc = w_first ? '0 : r_acc;
   assign w_base_cnt = w_first ? '0 : r_cnt;
   assign w_base_ovf = w_first ? 1'b0 : r_ovf;

   assign w_sum_full = (ACC_W+1)'(w_base_acc) + (ACC_W+1)'(bus.p_data);
   assign w_carry    = w_sum_full[ACC_W];

`ifdef BMULT_ACC_SAT_EN
   assign w_sum_next = w_carry ? {ACC_W{1'b1}} : w_sum_full[ACC_W-1:0];
`else
   assign w_sum_next = w_sum_full[ACC_W-1:0];
`endif

   assign w_cnt_next = w_base_cnt + CNT_W'(1);
   assign w_ovf_next = w_base_ovf | w_carry;
   assign w_term     = bus.p_last || (w_cnt_next == MAX_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_cnt   <= '0;
         r_out_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_ACCUM: begin
               if (w_accept) begin
                  if (w_term) begin
                     r_out_data  <= w_sum_next;
                     r_out_cnt   <= w_cnt_next;
                     r_out_ovf   <= w_ovf_next;
                     r_out_valid <= 1'b1;
                     r_acc       <= '0;
                     r_cnt       <= '0;
                     r_ovf       <= 1'b0;
                     r_state     <= S_HOLD;
                  end else begin
                     r_acc   <= w_sum_next;
                     r_cnt   <= w_cnt_next;
                     r_ovf   <= w_ovf_next;
                     r_state <= S_ACCUM;
                  end
               end
            end
            S_HOLD: begin
               // Result fields keep their values after the handshake.
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.p_ready   = w_p_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_cnt   = r_out_cnt;
   assign bus.out_ovf   = r_out_ovf;
   assign o_state       = r_state;

endmodule

// File: tb/tb_bmult_prod_accum.sv
// Bench for bmult_prod_accum: one 24-bit and one 16-bit accumulator driven in lockstep,
// checked every cycle against a sum-of-terms reference model.
module tb_bmult_prod_accum;

  localparam int P_W       = 16;
  localparam int MAX_TERMS = 16;
  localparam int CNT_W     = $clog2(MAX_TERMS + 1);
  localparam int RW        = 1 + CNT_W + 24;

  logic clk;
  logic rst;
  logic p_valid;
  logic [P_W-1:0] p_data;
  logic p_last;
  logic out_ready;
  logic [1:0] state_a;
  logic [1:0] state_b;

  bmult_prod_accum_if #(.P_W(P_W), .ACC_W(24), .CNT_W(CNT_W)) ifa ();
  bmult_prod_accum_if #(.P_W(P_W), .ACC_W(16), .CNT_W(CNT_W)) ifb ();

  assign ifa.p_valid   = p_valid;
  assign ifa.p_data    = p_data;
  assign ifa.p_last    = p_last;
  assign ifa.out_ready = out_ready;
  assign ifb.p_valid   = p_valid;
  assign ifb.p_data    = p_data;
  assign ifb.p_last    = p_last;
  assign ifb.out_ready = out_ready;

  bmult_prod_accum #(.P_W(P_W), .ACC_W(24), .MAX_TERMS(MAX_TERMS)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave), .o_state(state_a)
  );
  bmult_prod_accum #(.P_W(P_W), .ACC_W(16), .MAX_TERMS(MAX_TERMS)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave), .o_state(state_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [RW-1:0] exp_qa[$];
  logic [RW-1:0] exp_qb[$];
  bit      armed  = 1'b0;
  bit      m_hold = 1'b0;
  longint  m_sum  = 0;
  int      m_cnt  = 0;
  logic [23:0]      last_a;
  logic [15:0]      last_b;
  logic [CNT_W-1:0] last_cnt_a;
  logic             last_ovf_a;
  logic             last_ovf_b;

  // Expected {ovf, cnt, data} for a sum whose true total is known exactly.
  function automatic logic [RW-1:0] model_res(input longint sum, input int cnt, input int accw);
    longint lim;
    logic   ovf;
    longint d;
    lim = longint'(1) << accw;
    ovf = (sum >= lim);
`ifdef BMULT_ACC_SAT_EN
    d = ovf ? (lim - 1) : sum;
`else
    d = sum % lim;
`endif
    return {ovf, CNT_W'(cnt), 24'(d)};
  endfunction

  initial begin
    logic [RW-1:0] ea;
    logic [RW-1:0] eb;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_hold = 1'b0;
        m_sum  = 0;
        m_cnt  = 0;
        exp_qa.delete();
        exp_qb.delete();
        armed  = 1'b1;
      end else if (armed) begin
        check("p_ready_a", 32'(ifa.p_ready), 32'(!m_hold));
        check("p_ready_b", 32'(ifb.p_ready), 32'(!m_hold));
        check("out_valid_a", 32'(ifa.out_valid), 32'(m_hold));
        check("out_valid_b", 32'(ifb.out_valid), 32'(m_hold));
        if (m_hold) begin
          ea = exp_qa[0];
          eb = exp_qb[0];
          check("out_data_a", 32'(ifa.out_data), 32'(ea[23:0]));
          check("out_cnt_a",  32'(ifa.out_cnt),  32'(ea[24 +: CNT_W]));
          check("out_ovf_a",  32'(ifa.out_ovf),  32'(ea[RW-1]));
          check("out_data_b", 32'(ifb.out_data), 32'(eb[23:0]));
          check("out_cnt_b",  32'(ifb.out_cnt),  32'(eb[24 +: CNT_W]));
          check("out_ovf_b",  32'(ifb.out_ovf),  32'(eb[RW-1]));
          if (out_ready) begin
            last_a     = ifa.out_data;
            last_cnt_a = ifa.out_cnt;
            last_ovf_a = ifa.out_ovf;
            last_b     = ifb.out_data;
            last_ovf_b = ifb.out_ovf;
            void'(exp_qa.pop_front());
            void'(exp_qb.pop_front());
            m_hold = 1'b0;
          end
        end else if (p_valid) begin
          m_sum = m_sum + longint'(p_data);
          m_cnt++;
          if (p_last || m_cnt == MAX_TERMS) begin
            exp_qa.push_back(model_res(m_sum, m_cnt, 24));
            exp_qb.push_back(model_res(m_sum, m_cnt, 16));
            m_sum  = 0;
            m_cnt  = 0;
            m_hold = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [P_W-1:0] d, input logic last, input int gap);
    logic rdy;
    int   n;
    p_valid = 1'b1;
    p_data  = d;
    p_last  = last;
    n = 0;
    do begin
      @(negedge clk);
      rdy = ifa.p_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) check("send_timeout", 32'(0), 32'(1));
    p_valid = 1'b0;
    p_last  = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_hold && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (m_hold) check("drain_timeout", 32'(0), 32'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst     = 1'b1;
    p_valid = 1'b0;
    p_data  = '0;
    p_last  = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    @(negedge clk);
    check("rst_p_ready",   32'(ifa.p_ready),   32'(1));
    check("rst_out_valid", 32'(ifa.out_valid), 32'(0));
    check("rst_out_data",  32'(ifa.out_data),  32'(0));
    check("rst_out_cnt",   32'(ifa.out_cnt),   32'(0));
    check("rst_out_ovf",   32'(ifa.out_ovf),   32'(0));
    @(posedge clk);
    #1;

    // Basic back-to-back sum.
    send(16'd15, 1'b0, 0);
    send(16'd100, 1'b0, 0);
    send(16'd65535, 1'b0, 0);
    send(16'd1, 1'b1, 0);
    drain();
    check("basic_data", 32'(last_a), 32'(65651));
    check("basic_cnt",  32'(last_cnt_a), 32'(4));
    check("basic_ovf",  32'(last_ovf_a), 32'(0));

    // Backpressure on a single-term sum.
    rdy_mode = 2;
    send(16'd1234, 1'b1, 5);
    rdy_mode = 0;
    drain();
    check("bp_data", 32'(last_a), 32'(1234));
    check("bp_cnt",  32'(last_cnt_a), 32'(1));

    // Overflow, seen on the 16-bit instance.
    send(16'd65535, 1'b0, 0);
    send(16'd2, 1'b1, 0);
    drain();
`ifdef BMULT_ACC_SAT_EN
    check("ovf16_data", 32'(last_b), 32'(65535));
`else
    check("ovf16_data", 32'(last_b), 32'(1));
`endif
    check("ovf16_flag", 32'(last_ovf_b), 32'(1));
    check("ovf24_data", 32'(last_a), 32'(65537));
    check("ovf24_flag", 32'(last_ovf_a), 32'(0));

    // Forced termination at MAX_TERMS, then a fresh one-term sum.
    for (int i = 0; i < MAX_TERMS; i++) send(16'd3, 1'b0, 0);
    drain();
    check("max_data", 32'(last_a), 32'(48));
    check("max_cnt",  32'(last_cnt_a), 32'(16));
    send(16'd3, 1'b1, 0);
    drain();
    check("fresh_data", 32'(last_a), 32'(3));
    check("fresh_cnt",  32'(last_cnt_a), 32'(1));

    // Reset discards a partial sum.
    send(16'd500, 1'b0, 0);
    send(16'd700, 1'b0, 0);
    pulse_reset();
    send(16'd9, 1'b1, 0);
    drain();
    check("rstmid_data", 32'(last_a), 32'(9));
    check("rstmid_cnt",  32'(last_cnt_a), 32'(1));
    check("rstmid_ovf",  32'(last_ovf_a), 32'(0));

    // Idle gaps between terms.
    send(16'd10, 1'b0, 2);
    send(16'd20, 1'b0, 2);
    send(16'd30, 1'b1, 0);
    drain();
    check("gap_data", 32'(last_a), 32'(60));
    check("gap_cnt",  32'(last_cnt_a), 32'(3));

    // Zero-valued term still counts.
    send(16'd0, 1'b1, 0);
    drain();
    check("zero_cnt", 32'(last_cnt_a), 32'(1));

    // Randomized traffic with random backpressure and occasional resets.
    rdy_mode = 1;
    for (int i = 0; i < 120; i++) begin
      logic [P_W-1:0] d;
      case ($urandom_range(0, 3))
        0:       d = '0;
        1:       d = 16'hFFFF;
        default: d = P_W'($urandom_range(0, 65535));
      endcase
      send(d, ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
      if ($urandom_range(0, 29) == 0) pulse_reset();
    end
    send(16'd7, 1'b1, 0);
    rdy_mode = 0;
    drain();
    repeat (3) begin
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bmult_prod_accum.md
Name: bmult_prod_accum

Overview:
- Downstream consumer of the 8x8 bit-heap multiplier's 16-bit product `P`.
- Accumulates a stream of unsigned products into a dot-product result. Uses a valid/ready handshake on both sides.
- Terminates a sum on `p_last`, or when `MAX_TERMS` terms have been accepted.
- Presents the sum, the term count and an overflow flag on a held output register.

Parameters:
- P_W, 16, product width; matches the multiplier output width.
- ACC_W, 24, accumulator and result width; must be >= P_W.
- MAX_TERMS, 16, maximum terms per sum; must be >= 1. When the count reaches this value the sum terminates even without `p_last`.
- CNT_W, $clog2(MAX_TERMS+1), width of the term counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- p_valid  in  1  product valid.
- p_ready  out  1  accumulator can accept a product.
- p_data  in  P_W  unsigned product from the multiplier.
- p_last  in  1  marks the final term of the current sum.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_W  accumulated sum.
- out_cnt  out  CNT_W  number of terms in `out_data`.
- out_ovf  out  1  overflow occurred during this sum.

Behaviour:
- **States:** IDLE (no partial sum), ACCUM (partial sum open), HOLD (result waiting for downstream).
- **Reset:** when `rst`=1 at a clock edge:
  - state = IDLE;
  - internal accumulator, counter and sticky overflow = 0;
  - `out_valid`=0, `out_data`=0, `out_cnt`=0, `out_ovf`=0;
  - `p_ready` = 1 in the first cycle after reset.
  - Reset in any state discards the partial sum and any held result; nothing is emitted.
- **Input ready:** `p_ready` = 1 in IDLE and ACCUM, 0 in HOLD; it is a combinational decode of state only.
- **Accept:** a product is accepted when `p_valid && p_ready`. On accept:
  - `sum_next` = (state==IDLE ? 0 : acc) + zero-extend(`p_data`);
  - `cnt_next` = (state==IDLE ? 0 : cnt) + 1;
  - `ovf_next` = (state==IDLE ? 0 : ovf) | carry-out of the ACC_W-bit add.
- **Terminate:** if `p_last` is set or `cnt_next`==MAX_TERMS:
  - register `out_data`=`sum_next`, `out_cnt`=`cnt_next`, `out_ovf`=`ovf_next`;
  - `out_valid`=1, state=HOLD.
  - Otherwise latch acc, cnt and ovf, and state=ACCUM.
- **Latency:** the result is visible with `out_valid`=1 on the cycle after the terminating term is accepted.
- **No input:** when `p_valid`=0, acc, cnt and state are unchanged in IDLE and ACCUM.
- **HOLD:**
  - `out_data`, `out_cnt` and `out_ovf` are stable while `out_valid`=1 and `out_ready`=0.
  - On `out_valid && out_ready`: `out_valid`=0 and state=IDLE on the next edge. This gives one bubble: `p_ready` rises the cycle after the output handshake.
  - `out_data`, `out_cnt` and `out_ovf` keep their last values after the handshake; they are only meaningful while `out_valid`=1.
- **Edge cases:**
  - MAX_TERMS=1: every accepted product terminates a sum.
  - `p_last` on the term that also reaches MAX_TERMS: a single termination.
  - `p_last` in IDLE: a one-term sum.
  - `p_data`=0 still counts as a term.
- **Overflow (default build):** the sum wraps modulo 2^ACC_W and `out_ovf` reports it.

Optional Feature:
- Macro: BMULT_ACC_SAT_EN.
- **When defined:** an add that carries out clamps the accumulator to 2^ACC_W-1.
  - Later adds in the same sum stay clamped at all-ones.
  - `out_ovf` is still set.
- **When undefined:** modulo-2^ACC_W wrap, as described in Behaviour.
- Ports and timing are identical in both builds.

Test Plan:
- **Basic sum:** after reset, send 15, 100, 65535, 1 back-to-back with `p_last` on the 4th, `out_ready`=1.
  - Expect `out_valid` one cycle after the 4th accept, with `out_data`=65651, `out_cnt`=4, `out_ovf`=0.
  - `p_ready` is 0 for exactly one cycle, then 1.
- **Backpressure:** `p_last` on a single term 1234 with `out_ready`=0 for 5 cycles.
  - `out_valid`=1 and `out_data`=1234 held stable; `p_ready`=0 throughout.
  - Raise `out_ready`: `out_valid` drops next cycle, `p_ready`=1 the cycle after the handshake.
- **Overflow (ACC_W=16):** send 65535, then 2 with `p_last`.
  - Default build: `out_data`=1, `out_ovf`=1.
  - BMULT_ACC_SAT_EN build: `out_data`=65535, `out_ovf`=1.
- **Forced termination (MAX_TERMS=16):** send 16 products of value 3, `p_last` never set.
  - Result after the 16th accept: `out_data`=48, `out_cnt`=16.
  - A 17th product starts a fresh sum.
- **Reset mid-sum:** accept 500 and 700, assert `rst` for 1 cycle, then send 9 with `p_last`.
  - `out_data`=9, `out_cnt`=1, `out_ovf`=0.
  - `out_valid` never asserted for the discarded sum.
- **Gaps:** send 10, 20, 30 with 2-cycle `p_valid`=0 gaps, `p_last` on 30.
  - `out_data`=60, `out_cnt`=3; the accumulator is unchanged during the gaps.
